// File: rtl/alu_mem_unit.sv
// alu_mem_unit
//   Execute/memory stage of a single-cycle MIPS datapath: the 32-bit ALU with
//   its Zero flag, the PC incrementer and branch-target adder, and a
//   word-organised data memory. Everything is combinational except the
//   memory write and the memory clear on reset.
//
// Ports
//   clk           clock; state changes on the rising edge
//   rst           synchronous active-high reset; clears every memory word
//   pc            current instruction address
//   imm16         instruction immediate inst[15:0]
//   A, B          ALU operands
//   ALU_control   operation select (see the case statement below)
//   memWrite      data-memory write enable
//   memRead       data-memory read enable; readData is 0 when low
//   writeData     store data
//   Out           ALU result; also the data-memory byte address
//   Zero          1 when Out == 0
//   pc_plus4      pc + 4
//   branch_target pc_plus4 + (sign-extended imm16 << 2)
//   readData      load data

module alu_mem_unit #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALU_control,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [31:0] writeData,
    output logic [31:0] Out,
    output logic        Zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] readData
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic [31:0]          mem [MEM_WORDS];
    logic [ADDR_BITS-1:0] index;

    // ALU. Add and subtract simply wrap; there is no overflow detection.
    always_comb begin
        // NOTE: default assignment first so every path drives Out and no latch is inferred.
        Out = '0;
        case (ALU_control)
            OP_AND:  Out = A & B;
            OP_OR:   Out = A | B;
            OP_ADD:  Out = A + B;
            OP_XOR:  Out = A ^ B;
            OP_NOR:  Out = ~(A | B);
            OP_SLTU: Out = {31'b0, (A < B)};
            OP_SUB:  Out = A - B;
            OP_SLT:  Out = {31'b0, ($signed(A) < $signed(B))};
            default: Out = '0;
        endcase
    end

    assign Zero = ~|Out;

    // Branch offset is a word offset: sign-extend to 30 bits, then append 2'b00.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

    // Byte address -> word index: low two bits dropped (misaligned rounds
    // down), bits above the memory size dropped (addresses wrap).
    assign index = Out[ADDR_BITS+1:2];

    // Combinational read: with a simultaneous write the old word shows until
    // the edge, the new one right after it.
    assign readData = memRead ? mem[index] : 32'h0;

    // NOTE: the memory really is cleared on reset (every word, one edge),
    // because loads after reset must return 0; this costs a reset on every
    // storage bit instead of letting it map to plain RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                // NOTE: non-blocking for all sequential state so readers see pre-edge values.
                mem[i] <= '0;
            end
        end else if (memWrite) begin
            mem[index] <= writeData;
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
// Testbench for alu_mem_unit: a table of ALU vectors, hand-written
// sequences for adders, store/load, address wrap and reset, then a
// randomized run checked against a behavioural model (arithmetic on plain
// values plus an array standing in for the data memory).

module tb_alu_mem_unit;

    localparam int MEM_WORDS = 64;
    localparam int ADDR_BITS = 6;

    localparam logic [2:0] AND_OP  = 3'd0;
    localparam logic [2:0] OR_OP   = 3'd1;
    localparam logic [2:0] ADD_OP  = 3'd2;
    localparam logic [2:0] XOR_OP  = 3'd3;
    localparam logic [2:0] NOR_OP  = 3'd4;
    localparam logic [2:0] SLTU_OP = 3'd5;
    localparam logic [2:0] SUB_OP  = 3'd6;
    localparam logic [2:0] SLT_OP  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [15:0] imm16;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALU_control;
    logic        memWrite;
    logic        memRead;
    logic [31:0] writeData;
    logic [31:0] Out;
    logic        Zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] readData;

    int pass_count = 0;
    int total_count = 0;

    logic [31:0] model_mem [MEM_WORDS];

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } alu_vec_t;

    alu_vec_t vecs [8];

    alu_mem_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .imm16         (imm16),
        .A             (A),
        .B             (B),
        .ALU_control   (ALU_control),
        .memWrite      (memWrite),
        .memRead       (memRead),
        .writeData     (writeData),
        .Out           (Out),
        .Zero          (Zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .readData      (readData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        int     sa = int'(a);
        int     sb = int'(b);
        case (op)
            AND_OP:  return a & b;
            OR_OP:   return a | b;
            ADD_OP:  return 32'((ua + ub) % 64'h1_0000_0000);
            XOR_OP:  return a ^ b;
            NOR_OP:  return ~(a | b);
            SLTU_OP: return (ua < ub) ? 32'd1 : 32'd0;
            SUB_OP:  return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic int model_index(input logic [31:0] byte_addr);
        return int'((longint'(byte_addr) / 4) % MEM_WORDS);
    endfunction

    // Drive inputs after a falling edge, settle 1 time unit.
    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic rd, input logic [31:0] wd);
        @(negedge clk);
        ALU_control = op;
        A = a;
        B = b;
        memWrite = wr;
        memRead = rd;
        writeData = wd;
        #1;
    endtask

    // One rising edge; the model memory is updated by the same rules.
    task automatic clock_edge();
        int idx;
        idx = model_index(model_alu(ALU_control, A, B));
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
        end else if (memWrite) begin
            model_mem[idx] = writeData;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_out;
        int          simm;

        vecs[0] = '{"and",  AND_OP,  32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 1'b1};
        vecs[1] = '{"or",   OR_OP,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        vecs[2] = '{"add",  ADD_OP,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        vecs[3] = '{"xor",  XOR_OP,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        vecs[4] = '{"nor",  NOR_OP,  32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FF00, 1'b0};
        vecs[5] = '{"sub",  SUB_OP,  32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FF1F, 1'b0};
        vecs[6] = '{"slt",  SLT_OP,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[7] = '{"sltu", SLTU_OP, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        pc = '0;
        imm16 = '0;
        A = '0;
        B = '0;
        ALU_control = ADD_OP;
        memWrite = 1'b0;
        memRead = 1'b0;
        writeData = '0;
        clock_edge();
        rst = 1'b0;

        // Reset state: reads return 0.
        apply(ADD_OP, 32'd0, 32'd0, 1'b0, 1'b1, '0);
        check("reset_read_w0", readData, 32'h0);
        apply(ADD_OP, 32'd252, 32'd0, 1'b0, 1'b1, '0);
        check("reset_read_w63", readData, 32'h0);

        // ALU table.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, '0);
            check({vecs[i].name, "_out"}, Out, vecs[i].exp_out);
            check({vecs[i].name, "_zero"}, 32'(Zero), 32'(vecs[i].exp_zero));
        end

        // Adders.
        @(negedge clk);
        pc = 32'h0000_0100;
        imm16 = 16'hFFFF;
        #1;
        check("pc_plus4", pc_plus4, 32'h0000_0104);
        check("branch_back", branch_target, 32'h0000_0100);
        pc = 32'hFFFF_FFFC;
        imm16 = 16'h0001;
        #1;
        check("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
        check("branch_after_wrap", branch_target, 32'h0000_0004);

        // Store then load; misaligned rounds down; memRead gates.
        apply(ADD_OP, 32'd8, 32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        clock_edge();
        apply(ADD_OP, 32'd8, 32'd0, 1'b0, 1'b1, '0);
        check("load_addr8", readData, 32'hDEAD_BEEF);
        apply(ADD_OP, 32'd10, 32'd0, 1'b0, 1'b1, '0);
        check("load_addr10", readData, 32'hDEAD_BEEF);
        apply(ADD_OP, 32'd8, 32'd0, 1'b0, 1'b0, '0);
        check("load_rd_off", readData, 32'h0);

        // Address wrap.
        apply(ADD_OP, 32'd4, 32'd0, 1'b1, 1'b0, 32'h1234_5678);
        clock_edge();
        apply(ADD_OP, 32'(MEM_WORDS * 4), 32'd4, 1'b0, 1'b1, '0);
        check("load_wrap", readData, 32'h1234_5678);

        // Read and write together: old word before edge, new word after.
        apply(ADD_OP, 32'd8, 32'd0, 1'b1, 1'b1, 32'hCAFE_F00D);
        check("rw_before_edge", readData, 32'hDEAD_BEEF);
        clock_edge();
        check("rw_after_edge", readData, 32'hCAFE_F00D);

        // Reset with a pending write: everything clears, write is dropped.
        apply(ADD_OP, 32'd8, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
        apply(ADD_OP, 32'd8, 32'd0, 1'b0, 1'b1, '0);
        check("post_rst_addr8", readData, 32'h0);
        apply(ADD_OP, 32'd4, 32'd0, 1'b0, 1'b1, '0);
        check("post_rst_addr4", readData, 32'h0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600));
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600));
            apply(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            pc = $urandom & 32'hFFFF_FFFC;
            imm16 = 16'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            #1;
            exp_out = model_alu(op, a, b);
            simm = int'($signed(imm16));
            check("rand_out", Out, exp_out);
            check("rand_zero", 32'(Zero), (exp_out == 0) ? 32'd1 : 32'd0);
            check("rand_pc_plus4", pc_plus4, 32'((longint'(pc) + 4) % 64'h1_0000_0000));
            check("rand_branch", branch_target,
                  32'((longint'(pc) + 4 + 4 * longint'(simm) + 64'h2_0000_0000) % 64'h1_0000_0000));
            check("rand_read", readData, memRead ? model_mem[model_index(exp_out)] : 32'h0);
            clock_edge();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
